mac_vec: RTL and testbench
==========================

MAC_VEC -- requirements
Module: mac_vec

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed operand width per lane.
REQ-002 SHALL have parameter ACC_W, default 16, signed accumulator width; ACC_W >= 2*IN_W.
REQ-003 SHALL have parameter LANES, default 4, operand pairs per sample; power of two, >= 1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: clr_n  input  1  synchronous active-low accumulator clear.
REQ-008 Port: in_vld  input  1  a/b hold a valid sample this cycle.
REQ-009 Port: a  input  LANES*IN_W  signed lane operands; lane i = bits [i*IN_W +: IN_W].
REQ-010 Port: b  input  LANES*IN_W  signed lane operands, same packing as a.
REQ-011 Port: acc  output  ACC_W  signed accumulator value.
REQ-012 Port: out_vld  output  1  one-cycle pulse when acc has just absorbed a sample.
REQ-013 Port: of  output  1  sticky overflow flag.
REQ-014 Port: uf  output  1  sticky underflow flag.

Function
REQ-015 Stage 1 SHALL register dot = sum over lanes of a[i]*b[i], full precision, SUM_W = 2*IN_W + log2(LANES), plus a valid bit, on each edge where in_vld=1.
REQ-016 Stage 2 SHALL form acc + dot in max(ACC_W,SUM_W)+1 bits; result > max ACC_W signed sets of; result < min sets uf.
REQ-017 Latency SHALL be 2 cycles: sample accepted at edge N, acc updated and out_vld=1 after edge N+1.
REQ-018 One sample per cycle SHALL be accepted; there is no backpressure.
REQ-019 of/uf SHALL stay set until clr_n or rst_n; both may be set simultaneously.
REQ-020 acc SHALL be unchanged and out_vld=0 on cycles with no valid sample in stage 2.
REQ-021 clr_n=0 at an edge SHALL set acc=0, of=0, uf=0, out_vld=0, clear the stage-1 valid bit, and discard any in_vld sample on that edge.
REQ-022 The first sample accepted on the edge after clr_n returns high SHALL accumulate from 0.

Reset
REQ-023 rst_n=0 SHALL immediately force acc=0, of=0, uf=0, out_vld=0 and clear the stage-1 valid and data registers, regardless of clk.
REQ-024 A sample in flight when rst_n asserts SHALL be lost; after release, operation resumes with the first new in_vld.

Configuration
REQ-025 Macro MAC_VEC_SAT_EN SHALL select the overflow policy.
REQ-026 With MAC_VEC_SAT_EN defined, acc SHALL clamp to max/min ACC_W signed on overflow/underflow.
REQ-027 Without it, acc SHALL wrap (low ACC_W bits of the sum); flags behave identically in both builds.

Structure
REQ-028 Package mac_pkg SHALL hold the SUM_W width function and saturation max/min constants as functions of ACC_W.
REQ-029 Sub-module mac_dot SHALL implement stage 1 (lane multipliers, adder tree, register); mac_vec holds stage 2 and the flags.

Verification (IN_W=8, ACC_W=16, LANES=4)
REQ-030 rst_n low mid-stream -> acc=0, of=uf=out_vld=0 with no clock edge.
REQ-031 a={2,-2,-3,1}, b={5,5,8,1}, one sample -> 2 cycles later acc=-23, one-cycle out_vld pulse.
REQ-032 all lanes a=127, b=127 -> of=1; acc=32767 (SAT) or -1020 (wrap); of still 1 after further in-range samples.
REQ-033 all lanes a=-128, b=127 -> uf=1; acc=-32768 (SAT) or 512 (wrap).
REQ-034 clr_n=0 with stage 1 full and in_vld=1 -> acc=0, flags 0, no out_vld the next cycle; next sample accumulates from 0.
REQ-035 back-to-back in_vld for 8 cycles with a=1, b=1 in all lanes -> acc steps by 4 each cycle to 32, out_vld high for 8 consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared width and saturation helpers for the vector MAC.
package mac_pkg;

  // Width of a full-precision dot product over 'lanes' signed in_w x in_w products.
  function automatic int sum_w(input int in_w, input int lanes);
    return 2 * in_w + $clog2(lanes);
  endfunction

  function automatic int max_w(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mac_dot.sv
// Stage 1 of the vector MAC: lane multipliers, lane summation and the dot-product register.
module mac_dot
  import mac_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int LANES = 4,
  parameter int SUM_W = sum_w(IN_W, LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_n,
  input  logic                    in_vld,
  input  logic [LANES*IN_W-1:0]   a,
  input  logic [LANES*IN_W-1:0]   b,
  output logic [SUM_W-1:0]        dot,
  output logic                    dot_vld
);

  logic signed [2*IN_W-1:0] w_prod [LANES];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  r_dot;
  logic                     r_dot_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_prod[i] = $signed(a[i*IN_W +: IN_W]) * $signed(b[i*IN_W +: IN_W]);
  end

  // Each product is sign-extended before summing so the total never loses precision.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + SUM_W'(w_prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dot     <= '0;
      r_dot_vld <= 1'b0;
    end else if (!clr_n) begin
      r_dot     <= '0;
      r_dot_vld <= 1'b0;
    end else begin
      r_dot_vld <= in_vld;
      if (in_vld) begin
        r_dot <= w_sum;
      end
    end
  end

  assign dot     = r_dot;
  assign dot_vld = r_dot_vld;

endmodule

// File: rtl/mac_vec.sv
// Two-stage signed vector multiply-accumulate with sticky overflow/underflow flags.
// Build option MAC_VEC_SAT_EN: clamp acc on overflow/underflow instead of wrapping.
module mac_vec
  import mac_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_n,
  input  logic                    in_vld,
  input  logic [LANES*IN_W-1:0]   a,
  input  logic [LANES*IN_W-1:0]   b,
  output logic [ACC_W-1:0]        acc,
  output logic                    out_vld,
  output logic                    of,
  output logic                    uf
);

  localparam int SUM_W = sum_w(IN_W, LANES);
  localparam int EXT_W = max_w(ACC_W, SUM_W) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(sat_min(ACC_W));
  localparam logic signed [EXT_W-1:0] ACC_MAX_X = EXT_W'(sat_max(ACC_W));
  localparam logic signed [EXT_W-1:0] ACC_MIN_X = EXT_W'(sat_min(ACC_W));

  // Handshake: in_vld qualifies a/b on the edge it is sampled and is always
  // accepted (no ready); out_vld pulses for exactly the cycle after acc absorbs it.
  logic [SUM_W-1:0]         w_dot;
  logic                     w_dot_vld;
  logic signed [EXT_W-1:0]  w_sum;
  logic                     w_of;
  logic                     w_uf;
  logic signed [ACC_W-1:0]  w_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_vld;
  logic                     r_of;
  logic                     r_uf;

  mac_dot #(
    .IN_W  (IN_W),
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_dot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_n   (clr_n),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .dot     (w_dot),
    .dot_vld (w_dot_vld)
  );

  assign w_sum = EXT_W'(r_acc) + EXT_W'($signed(w_dot));
  assign w_of  = (w_sum > ACC_MAX_X);
  assign w_uf  = (w_sum < ACC_MIN_X);

`ifdef MAC_VEC_SAT_EN
  assign w_next = w_of ? ACC_MAX : (w_uf ? ACC_MIN : w_sum[ACC_W-1:0]);
`else
  assign w_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_out_vld <= 1'b0;
      r_of      <= 1'b0;
      r_uf      <= 1'b0;
    end else if (!clr_n) begin
      r_acc     <= '0;
      r_out_vld <= 1'b0;
      r_of      <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      r_out_vld <= w_dot_vld;
      if (w_dot_vld) begin
        r_acc <= w_next;
        r_of  <= r_of | w_of;
        r_uf  <= r_uf | w_uf;
      end
    end
  end

  assign acc     = r_acc;
  assign out_vld = r_out_vld;
  assign of      = r_of;
  assign uf      = r_uf;

endmodule

// File: tb/tb_mac_vec.sv
// Directed self-checking bench for mac_vec (IN_W=8, ACC_W=16, LANES=4), both overflow builds.
module tb_mac_vec;

  logic               clk;
  logic               rst_n;
  logic               clr_n;
  logic               in_vld;
  logic [31:0]        a;
  logic [31:0]        b;
  logic signed [15:0] acc;
  logic               out_vld;
  logic               of;
  logic               uf;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MAC_VEC_SAT_EN
  localparam int EXP_OF_ACC   = 32767;
  localparam int EXP_OF_ACC2  = 32767;
  localparam int EXP_UF_ACC   = -32768;
  localparam int EXP_BOTH_ACC = 31748;
  localparam int EXP_BOTH_OF  = 0;
`else
  localparam int EXP_OF_ACC   = -1020;
  localparam int EXP_OF_ACC2  = -1016;
  localparam int EXP_UF_ACC   = 512;
  localparam int EXP_BOTH_ACC = -508;
  localparam int EXP_BOTH_OF  = 1;
`endif

  mac_vec #(
    .IN_W  (8),
    .ACC_W (16),
    .LANES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_n   (clr_n),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .acc     (acc),
    .out_vld (out_vld),
    .of      (of),
    .uf      (uf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [31:0] v;
    v[7:0]   = 8'(l0);
    v[15:8]  = 8'(l1);
    v[23:16] = 8'(l2);
    v[31:24] = 8'(l3);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] av, input logic [31:0] bv);
    in_vld = vld;
    a      = av;
    b      = bv;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int e_acc, input logic e_vld,
                             input logic e_of, input logic e_uf);
    check({tag, ".acc"}, acc, e_acc);
    check({tag, ".out_vld"}, {31'd0, out_vld}, {31'd0, e_vld});
    check({tag, ".of"}, {31'd0, of}, {31'd0, e_of});
    check({tag, ".uf"}, {31'd0, uf}, {31'd0, e_uf});
  endtask

  task automatic clear();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_n = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    tick();
    check_state("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single mixed-sign sample: 2*5 - 2*5 - 3*8 + 1*1 = -23
    drive(1'b1, pack4(2, -2, -3, 1), pack4(5, 5, 8, 1));
    tick();
    drive(1'b0, '0, '0);
    check_state("lat1", 0, 1'b0, 1'b0, 1'b0);
    tick();
    check_state("dot", -23, 1'b1, 1'b0, 1'b0);
    tick();
    check_state("hold", -23, 1'b0, 1'b0, 1'b0);
    clear();

    // Positive overflow: 4*127*127 = 64516
    drive(1'b1, pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("ovf", EXP_OF_ACC, 1'b1, 1'b1, 1'b0);
    drive(1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("ovf_sticky", EXP_OF_ACC2, 1'b1, 1'b1, 1'b0);
    clear();
    check_state("clr_ovf", 0, 1'b0, 1'b0, 1'b0);

    // Underflow: 4*(-128)*127 = -65024
    drive(1'b1, pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("udf", EXP_UF_ACC, 1'b1, 1'b0, 1'b1);
    drive(1'b1, pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("udf_then_pos", EXP_BOTH_ACC, 1'b1, EXP_BOTH_OF[0], 1'b1);

    // Clear with stage 1 full and a new sample offered on the clearing edge
    drive(1'b1, pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
    tick();
    drive(1'b1, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    drive(1'b0, '0, '0);
    check_state("clr_full", 0, 1'b0, 1'b0, 1'b0);
    tick();
    check_state("clr_drop", 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("after_clr", 8, 1'b1, 1'b0, 1'b0);
    clear();

    // Back-to-back stream of eight unit samples
    drive(1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    tick();
    check({"stream0.out_vld"}, {31'd0, out_vld}, 32'sd0);
    for (int j = 1; j <= 8; j++) begin
      if (j == 8) drive(1'b0, '0, '0);
      tick();
      check($sformatf("stream%0d.acc", j), acc, 4 * j);
      check($sformatf("stream%0d.out_vld", j), {31'd0, out_vld}, 32'sd1);
    end
    tick();
    check_state("stream_end", 32, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with a sample in flight and of set
    drive(1'b1, pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
    tick();
    tick();
    check({"pre_rst.of"}, {31'd0, of}, 32'sd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_state("rst_lost", 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    tick();
    drive(1'b0, '0, '0);
    tick();
    check_state("rst_resume", 4, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
